// File: rtl/prv_trap_pkg.sv
// Shared types, cause-code constants and the exception priority encoder
// for the machine-mode trap sequencer.
package prv_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_t;

    localparam logic [3:0] BREAKPOINT        = 4'd3;
    localparam int         IRQ_M_SOFT        = 3;
    localparam int         IRQ_M_TIMER       = 7;
    localparam int         IRQ_M_EXT         = 11;
    localparam int         IRQ_PLATFORM_BASE = 16;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } exc_sel_t;

    // Breakpoint outranks everything; the rest resolve lowest cause first.
    function automatic exc_sel_t exc_prio_enc(input logic [15:0] vec);
        exc_sel_t sel;
        sel.valid = |vec;
        sel.code  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) sel.code = 4'(i);
        end
        if (vec[BREAKPOINT]) sel.code = BREAKPOINT;
        return sel;
    endfunction

endpackage

// File: rtl/prv_irq_prio_enc.sv
// Fixed-priority interrupt encoder: external, software, timer, then the
// highest-numbered platform line. Standard lines outside that set are ignored.
module prv_irq_prio_enc
    import prv_trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0]       pending_i,
    output logic                     valid_o,
    output logic [$clog2(XLEN)-1:0]  code_o
);

    localparam int CW = $clog2(XLEN);

    // Later assignments override earlier ones, so lowest priority goes first.
    always_comb begin
        valid_o = 1'b0;
        code_o  = '0;
        for (int i = IRQ_PLATFORM_BASE; i < NUM_IRQ; i++) begin
            if (pending_i[i]) begin
                valid_o = 1'b1;
                code_o  = CW'(i);
            end
        end
        if (pending_i[IRQ_M_TIMER]) begin
            valid_o = 1'b1;
            code_o  = CW'(IRQ_M_TIMER);
        end
        if (pending_i[IRQ_M_SOFT]) begin
            valid_o = 1'b1;
            code_o  = CW'(IRQ_M_SOFT);
        end
        if (pending_i[IRQ_M_EXT]) begin
            valid_o = 1'b1;
            code_o  = CW'(IRQ_M_EXT);
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Sequences exceptions, mret and interrupts through a flush handshake with the
// hazard unit, then emits a one-cycle redirect plus CSR commit strobe.
module prv_trap_sequencer
    import prv_trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [15:0]        exc_vec,
    input  logic [XLEN-1:0]    exc_epc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               mret,
    input  logic [XLEN-1:0]    irq_epc,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic               mstatus_mie,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    mepc,
    input  logic               pipe_clear_done,
    output logic               pipe_clear_req,
    output logic               insert_pc,
    output logic [XLEN-1:0]    priv_pc,
    output logic               trap_commit,
    output logic               mret_commit,
    output logic [XLEN-1:0]    mcause_wdata,
    output logic [XLEN-1:0]    mepc_wdata,
    output logic [XLEN-1:0]    mtval_wdata,
    output logic               busy
);

    localparam int CW = $clog2(XLEN);

    trap_state_t     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            is_mret_q, is_mret_d;

    exc_sel_t        exc_sel;
    logic            irq_valid;
    logic [CW-1:0]   irq_code;
    logic            irq_take;
    logic            capture;
    logic [XLEN-1:0] tvec_base;

    prv_irq_prio_enc #(
        .XLEN    (XLEN),
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_enc (
        .pending_i (irq_in & mie),
        .valid_o   (irq_valid),
        .code_o    (irq_code)
    );

    assign exc_sel   = exc_prio_enc(exc_vec);
    assign irq_take  = mstatus_mie & irq_valid;
    assign capture   = (state_q == ST_IDLE) & (exc_sel.valid | mret | irq_take);
    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (capture) state_d = ST_FLUSH;
            ST_FLUSH:    if (pipe_clear_done) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_clear_req = 1'b0;
        insert_pc      = 1'b0;
        trap_commit    = 1'b0;
        mret_commit    = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                pipe_clear_req = 1'b1;
                busy           = 1'b1;
            end
            ST_REDIRECT: begin
                insert_pc   = 1'b1;
                trap_commit = ~is_mret_q;
                mret_commit = is_mret_q;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture datapath: everything the redirect needs is frozen at capture.
    always_comb begin
        pc_d      = pc_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tval_d    = tval_q;
        is_mret_d = is_mret_q;
        if (capture) begin
            if (exc_sel.valid) begin
                is_mret_d = 1'b0;
                pc_d      = tvec_base;
                cause_d   = {{(XLEN-4){1'b0}}, exc_sel.code};
                epc_d     = exc_epc;
                tval_d    = exc_tval;
            end else if (mret) begin
                is_mret_d = 1'b1;
                pc_d      = mepc;
            end else begin
                is_mret_d = 1'b0;
                pc_d      = (mtvec[1:0] == MTVEC_VECTORED)
                          ? tvec_base + (XLEN'(irq_code) << 2)
                          : tvec_base;
                cause_d   = {1'b1, {(XLEN-1-CW){1'b0}}, irq_code};
                epc_d     = irq_epc;
                tval_d    = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            tval_q    <= '0;
            is_mret_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            tval_q    <= tval_d;
            is_mret_q <= is_mret_d;
        end
    end

    assign priv_pc      = pc_q;
    assign mcause_wdata = cause_q;
    assign mepc_wdata   = epc_q;
    assign mtval_wdata  = tval_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Directed bench for prv_trap_sequencer: expected redirects are queued as
// stimulus is issued and checked by a monitor whenever insert_pc fires.
module tb_prv_trap_sequencer;

  localparam int XLEN = 32;
  localparam int NUM_IRQ = 32;
  localparam int W = 1 + 4 * XLEN;

  // clock / reset
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  logic [15:0]        exc_vec = '0;
  logic [XLEN-1:0]    exc_epc = '0;
  logic [XLEN-1:0]    exc_tval = '0;
  logic               mret = 1'b0;
  logic [XLEN-1:0]    irq_epc = '0;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic [NUM_IRQ-1:0] mie = '0;
  logic               mstatus_mie = 1'b0;
  logic [XLEN-1:0]    mtvec = '0;
  logic [XLEN-1:0]    mepc = '0;
  logic               pipe_clear_done = 1'b1;
  logic               pipe_clear_req;
  logic               insert_pc;
  logic [XLEN-1:0]    priv_pc;
  logic               trap_commit;
  logic               mret_commit;
  logic [XLEN-1:0]    mcause_wdata;
  logic [XLEN-1:0]    mepc_wdata;
  logic [XLEN-1:0]    mtval_wdata;
  logic               busy;

  prv_trap_sequencer #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .exc_vec         (exc_vec),
    .exc_epc         (exc_epc),
    .exc_tval        (exc_tval),
    .mret            (mret),
    .irq_epc         (irq_epc),
    .irq_in          (irq_in),
    .mie             (mie),
    .mstatus_mie     (mstatus_mie),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .pipe_clear_done (pipe_clear_done),
    .pipe_clear_req  (pipe_clear_req),
    .insert_pc       (insert_pc),
    .priv_pc         (priv_pc),
    .trap_commit     (trap_commit),
    .mret_commit     (mret_commit),
    .mcause_wdata    (mcause_wdata),
    .mepc_wdata      (mepc_wdata),
    .mtval_wdata     (mtval_wdata),
    .busy            (busy)
  );

  // scoreboard: {is_mret, pc, cause, epc, tval}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_trap(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                           input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
    exp_q.push_back({1'b0, pc, cause, epc, tval});
  endtask

  task automatic push_mret(input logic [XLEN-1:0] pc);
    exp_q.push_back({1'b1, pc, {(3*XLEN){1'b0}}});
  endtask

  // monitor
  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (insert_pc) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_redirect: got priv_pc 0x%08h expected no redirect at %0t", priv_pc, $time);
      end else begin
        e = exp_q.pop_front();
        cmp("mret_commit", XLEN'(mret_commit), XLEN'(e[W-1]));
        cmp("trap_commit", XLEN'(trap_commit), XLEN'(!e[W-1]));
        cmp("priv_pc", priv_pc, e[4*XLEN-1:3*XLEN]);
        if (!e[W-1]) begin
          cmp("mcause_wdata", mcause_wdata, e[3*XLEN-1:2*XLEN]);
          cmp("mepc_wdata", mepc_wdata, e[2*XLEN-1:XLEN]);
          cmp("mtval_wdata", mtval_wdata, e[XLEN-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) cmp("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_no_trap(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      cmp(name, XLEN'(busy), 32'd0);
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;

    #2 nRST = 1'b0;
    #6;
    cmp("rst_busy", XLEN'(busy), 32'd0);
    cmp("rst_pipe_clear_req", XLEN'(pipe_clear_req), 32'd0);
    cmp("rst_insert_pc", XLEN'(insert_pc), 32'd0);
    cmp("rst_priv_pc", priv_pc, 32'd0);
    cmp("rst_mcause", mcause_wdata, 32'd0);
    step();
    nRST = 1'b1;

    // exception, causes 2 and 8, minimum latency
    exc_vec = 16'h0104; exc_epc = 32'h100; exc_tval = 32'hDEAD; mtvec = 32'h8000_0001;
    push_trap(32'h8000_0000, 32'd2, 32'h100, 32'hDEAD);
    step();
    exc_vec = '0;
    cmp("t1_req_n1", XLEN'(pipe_clear_req), 32'd1);
    cmp("t1_insert_n1", XLEN'(insert_pc), 32'd0);
    step();
    cmp("t1_insert_n2", XLEN'(insert_pc), 32'd1);
    cmp("t1_req_n2", XLEN'(pipe_clear_req), 32'd0);
    step();
    cmp("t1_busy_n3", XLEN'(busy), 32'd0);

    // breakpoint outranks lower cause 0
    exc_vec = 16'h0009; exc_epc = 32'h104; exc_tval = 32'h0;
    push_trap(32'h8000_0000, 32'd3, 32'h104, 32'h0);
    step();
    exc_vec = '0;
    wait_idle();

    // interrupts 7 and 11, vectored
    mie = '1; mstatus_mie = 1'b1; irq_epc = 32'h200;
    irq_in = (32'd1 << 7) | (32'd1 << 11);
    push_trap(32'h8000_002C, 32'h8000_000B, 32'h200, 32'h0);
    step();
    irq_in = '0;
    wait_idle();

    // mret beats a pending interrupt; interrupt follows back-to-back
    mret = 1'b1; mepc = 32'h400; irq_in = 32'd1 << 7; irq_epc = 32'h300;
    push_mret(32'h400);
    push_trap(32'h8000_001C, 32'h8000_0007, 32'h300, 32'h0);
    step();
    mret = 1'b0;
    step();
    step();
    cmp("t3_idle_n3", XLEN'(busy), 32'd0);
    step();
    cmp("t3_busy_n4", XLEN'(busy), 32'd1);
    irq_in = '0;
    wait_idle();

    // flush stall of 5 cycles, exc_vec toggling meanwhile
    mtvec = 32'h0000_1000; exc_vec = 16'h0100; exc_epc = 32'h500; exc_tval = 32'h55;
    push_trap(32'h0000_1000, 32'd8, 32'h500, 32'h55);
    step();
    pipe_clear_done = 1'b0;
    req_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      if (pipe_clear_req) req_cycles++;
      cmp("t4_no_insert", XLEN'(insert_pc), 32'd0);
      exc_vec = 16'(32'h0001 << k) | 16'h0008;
      step();
    end
    if (pipe_clear_req) req_cycles++;
    exc_vec = '0;
    pipe_clear_done = 1'b1;
    step();
    cmp("t4_req_cycles", XLEN'(req_cycles), 32'd6);
    cmp("t4_insert", XLEN'(insert_pc), 32'd1);
    wait_idle();

    // platform interrupts 16 and 20
    mtvec = 32'h8000_0101; mie = (32'd1 << 16) | (32'd1 << 20);
    irq_in = (32'd1 << 16) | (32'd1 << 20); mstatus_mie = 1'b0; irq_epc = 32'h700;
    check_no_trap("t5_gie_off", 3);
    mie = '1; irq_in = (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 13); mstatus_mie = 1'b1;
    check_no_trap("t5_ignored_bits", 3);
    mie = (32'd1 << 16) | (32'd1 << 20); irq_in = (32'd1 << 16) | (32'd1 << 20);
    push_trap(32'h8000_0150, 32'h8000_0014, 32'h700, 32'h0);
    step();
    irq_in = '0;
    wait_idle();

    // reset during FLUSH abandons the trap, then it is re-taken
    mtvec = 32'h8000_0001; mie = '1; irq_in = 32'd1 << 11; irq_epc = 32'h600;
    pipe_clear_done = 1'b0;
    step();
    cmp("t6_req", XLEN'(pipe_clear_req), 32'd1);
    #2 nRST = 1'b0;
    #1;
    cmp("t6_rst_busy", XLEN'(busy), 32'd0);
    cmp("t6_rst_req", XLEN'(pipe_clear_req), 32'd0);
    cmp("t6_rst_insert", XLEN'(insert_pc), 32'd0);
    cmp("t6_rst_trap_commit", XLEN'(trap_commit), 32'd0);
    cmp("t6_rst_priv_pc", priv_pc, 32'd0);
    cmp("t6_rst_mcause", mcause_wdata, 32'd0);
    cmp("t6_rst_mepc", mepc_wdata, 32'd0);
    cmp("t6_rst_mtval", mtval_wdata, 32'd0);
    step();
    step();
    nRST = 1'b1;
    pipe_clear_done = 1'b1;
    push_trap(32'h8000_002C, 32'h8000_000B, 32'h600, 32'h0);
    step();
    irq_in = '0;
    wait_idle();

    step();
    step();
    cmp("queue_empty", XLEN'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prv_trap_sequencer.md
# prv_trap_sequencer

Parametrised trap sequencer for the privileged unit. It accepts commit-stage exceptions, `mret`, and `NUM_IRQ` level-sensitive interrupt lines, and arbitrates them by fixed priority. It then runs a flush/redirect handshake with the hazard unit and emits the CSR update strobes and the redirect PC, in direct or vectored mode. It sits between the pipeline hazard logic and the machine-mode CSR file, replacing the single-shot `insert_pc`/`intr` path with a sequenced one.

## Interface
Parameters:
- `XLEN`, 32, datapath / CSR width.
- `NUM_IRQ`, 32, interrupt-line count; legal range 12..XLEN.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  clock.
- `nRST`  in  1  async active-low reset.
- `exc_vec`  in  16  commit-stage exceptions; bit i means cause code i.
- `exc_epc`  in  XLEN  PC of the faulting instruction.
- `exc_tval`  in  XLEN  trap value for the exception.
- `mret`  in  1  `mret` at commit.
- `irq_epc`  in  XLEN  PC of the next instruction to commit (interrupt return address).
- `irq_in`  in  NUM_IRQ  level interrupt pending; bit i means cause code i.
- `mie`  in  NUM_IRQ  interrupt enables.
- `mstatus_mie`  in  1  global interrupt enable.
- `mtvec`  in  XLEN  trap vector CSR.
- `mepc`  in  XLEN  current mepc, used for `mret`.
- `pipe_clear_done`  in  1  hazard unit reports the pipeline is drained.
- `pipe_clear_req`  out  1  flush request.
- `insert_pc`  out  1  one-cycle redirect strobe.
- `priv_pc`  out  XLEN  redirect target.
- `trap_commit`  out  1  one-cycle strobe: write mcause, mepc, mtval and push mstatus.
- `mret_commit`  out  1  one-cycle strobe: pop mstatus.
- `mcause_wdata`, `mepc_wdata`, `mtval_wdata`  out  XLEN  CSR write data, valid with `trap_commit`.
- `busy`  out  1  FSM not IDLE.

## Operation
- States are IDLE, FLUSH and REDIRECT.
- **IDLE, event selection.** Events are checked in priority order; the first one present is captured.
  - An exception wins if `exc_vec` is nonzero.
    - Priority: cause 3 first, then ascending cause code.
    - Captures `mcause = {0, code}`, `mepc = exc_epc` and `mtval = exc_tval`.
  - Otherwise `mret` is taken. It captures the `mepc` input as the return target.
  - Otherwise an interrupt is taken if `mstatus_mie` and `|(irq_in & mie)`.
    - Priority: 11, then 3, then 7, then the highest-numbered enabled bit ≥16.
    - Bits 0–2, 4–6, 8–10 and 12–15 are ignored.
    - Captures `mcause = {1, code}`, `mepc = irq_epc` and `mtval = 0`.
- **Target PC.** It is computed at capture and registered. The `mtvec` value used is the one sampled at capture.
  - Base is `{mtvec[XLEN-1:2], 2'b00}`.
  - Interrupt with `mtvec[1:0]==1`: target is base + 4·code, modulo 2^XLEN.
  - Modes 0, 2 and 3, and all exceptions: target is base.
  - `mret`: target is the captured `mepc` input.
- **State transitions.**
  - IDLE goes to FLUSH on capture.
  - FLUSH holds `pipe_clear_req=1` and moves to REDIRECT in the cycle after `pipe_clear_done` is sampled high.
  - REDIRECT asserts `insert_pc` together with either `trap_commit` or `mret_commit` for exactly one cycle, then returns to IDLE.
- **Inputs outside IDLE.** All event inputs are ignored in FLUSH and REDIRECT.
  - Interrupts are level-sensitive, so they are re-evaluated in IDLE.
  - An interrupt still pending after `mret` is taken from IDLE on the next cycle.
- **Output behaviour.**
  - `priv_pc` and the `*_wdata` outputs are driven from registers and are stable from FLUSH entry until the end of REDIRECT.
  - `busy` is high in FLUSH and REDIRECT.
- **Reset.** State goes to IDLE and all outputs and capture registers go to 0.
  - Reset mid-FLUSH or mid-REDIRECT abandons the trap: no strobe is issued.

## Timing
- Event sampled in IDLE at cycle N.
- `pipe_clear_req` is high from N+1.
- If `pipe_clear_done` is high at N+1, `insert_pc`/`trap_commit` fire at N+2 and the FSM is in IDLE at N+3. Minimum trap latency is therefore 2 cycles to redirect.
- `pipe_clear_done` held low stalls FLUSH indefinitely. It is not sampled in any other state.
- The earliest back-to-back event is captured in the IDLE cycle N+3.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.

## Structure
- Package `prv_trap_pkg`:
  - `trap_state_t` enum.
  - Exception and interrupt cause-code constants: `BREAKPOINT=3`, `IRQ_M_SOFT=3`, `IRQ_M_TIMER=7`, `IRQ_M_EXT=11`, `IRQ_PLATFORM_BASE=16`.
  - Mode constants `MTVEC_DIRECT=0`, `MTVEC_VECTORED=1`.
- Sub-module `prv_irq_prio_enc`, parametrised by `NUM_IRQ`.
  - Input: the masked pending vector.
  - Outputs: `valid` and a cause code of width `$clog2(XLEN)`.
- The exception priority encoding is a package function.

## Test plan
- `exc_vec=16'h0104` (causes 2 and 8), `exc_epc=0x100`, `exc_tval=0xDEAD`, `mtvec=0x8000_0001`, `pipe_clear_done` high at N+1 -> `trap_commit` and `insert_pc` at N+2, `mcause_wdata=2`, `mepc_wdata=0x100`, `mtval_wdata=0xDEAD`, `priv_pc=0x8000_0000`.
- `irq_in` bits 7 and 11 set, `mie` all-ones, `mstatus_mie=1`, vectored `mtvec=0x8000_0001` -> `mcause_wdata=0x8000_000B`, `priv_pc=0x8000_002C`, `mepc_wdata=irq_epc`.
- `mret` and interrupt 7 pending in the same cycle, `mepc=0x400` -> `mret_commit` with `priv_pc=0x400` first; interrupt 7 then taken from the following IDLE.
- `pipe_clear_done` held low for 5 cycles -> `pipe_clear_req` high for 6 cycles and no strobe; redirect occurs the cycle after `done` rises. Toggling `exc_vec` during the stall changes nothing.
- `NUM_IRQ=32`, platform bits 16 and 20 enabled, vectored mode -> cause 20 taken, `priv_pc=base+0x50`; with `mstatus_mie=0`, no trap occurs.
- `nRST` asserted during FLUSH -> all outputs 0, no `insert_pc`; after release, a pending enabled interrupt is re-taken normally.
